// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, parity modes and frame-length helper for uart_tx_fifo
package uart_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy output
//   clk, reset_n : clock, async active-low reset (clears pointers and level)
//   push_i/pop_i : write/read requests, ignored when full/empty
//   wdata_i      : word to write; rdata_o: head word (valid when level_o != 0)
//   level_o      : occupancy 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign do_push = push_i && level_q != (AW+1)'(DEPTH);
    assign do_pop  = pop_i && level_q != '0;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
        end else begin
            wp_q    <= wp_q + AW'(do_push);
            rp_q    <= rp_q + AW'(do_pop);
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rp_q];
    assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with configurable framing
//   clk, reset_n : clock, async active-low reset (aborts frame, empties FIFO)
//   tx_valid/tx_ready/tx_data : word push handshake into the FIFO
//   uart_tx      : serial line, idle high
//   busy         : FIFO not empty or a frame in progress
//   fifo_level   : FIFO occupancy 0..FIFO_DEPTH
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int MAIN_CLK   = 25000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DIV = MAIN_CLK / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $fatal(1, "uart_tx_fifo: illegal parameter combination");
    end

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d, head;
    logic                 par_q, par_d, tx_q, tx_d;
    logic                 pop, tick, empty;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (tx_valid && tx_ready),
        .pop_i   (pop),
        .wdata_i (tx_data),
        .rdata_o (head),
        .level_o (fifo_level)
    );

    assign tx_ready = fifo_level != LW'(FIFO_DEPTH);
    assign empty    = fifo_level == '0;
    assign tick     = cnt_q == '0;
    assign busy     = state_q != ST_IDLE || !empty;
    assign uart_tx  = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == ST_IDLE || tick) ? CW'(DIV - 1) : cnt_q - 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        pop     = 1'b0;
        case (state_q)
            ST_START:  if (tick) state_d = ST_DATA;
            ST_DATA:   if (tick) begin
                sh_d  = sh_q >> 1;
                bit_d = bit_q + 1'b1;
                if (bit_q == 4'(DATA_BITS - 1)) begin
                    bit_d   = '0;
                    state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP:   if (tick) begin
                bit_d = bit_q + 1'b1;
                if (bit_q == 4'(STOP_BITS - 1)) begin
                    bit_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
        // Heading for IDLE with data queued (from IDLE or end of STOP) chains straight into a new start bit.
        if (state_d == ST_IDLE && !empty) begin
            pop     = 1'b1;
            state_d = ST_START;
            sh_d    = head;
            par_d   = (^head) ^ (PARITY == PAR_ODD);
            bit_d   = '0;
        end
        tx_d = (state_d == ST_START) ? 1'b0 :
               (state_d == ST_DATA) ? sh_d[0] :
               (state_d == ST_PARITY) ? par_d : 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo in 8N1, 7E2 and 8O1 configurations
module tb_uart_tx_fifo;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       vld = 1'b0;
    logic [8:0] d = '0;
    int         sel = 0;
    logic       tx0, tx1, tx2, rdy0, rdy1, rdy2, bz0, bz1, bz2;
    logic [2:0] lv0, lv1, lv2;
    logic       line_m, rdy_m, busy_m;
    logic [2:0] lvl_m;
    int         checks = 0;
    int         errors = 0;
    bit         exp_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.MAIN_CLK(400), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .reset_n(reset_n), .tx_valid(vld && sel == 0), .tx_ready(rdy0),
        .tx_data(d[7:0]), .uart_tx(tx0), .busy(bz0), .fifo_level(lv0));
    uart_tx_fifo #(.MAIN_CLK(400), .BAUD(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .reset_n(reset_n), .tx_valid(vld && sel == 1), .tx_ready(rdy1),
        .tx_data(d[6:0]), .uart_tx(tx1), .busy(bz1), .fifo_level(lv1));
    uart_tx_fifo #(.MAIN_CLK(400), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .reset_n(reset_n), .tx_valid(vld && sel == 2), .tx_ready(rdy2),
        .tx_data(d[7:0]), .uart_tx(tx2), .busy(bz2), .fifo_level(lv2));

    assign line_m = sel == 0 ? tx0 : sel == 1 ? tx1 : tx2;
    assign rdy_m  = sel == 0 ? rdy0 : sel == 1 ? rdy1 : rdy2;
    assign busy_m = sel == 0 ? bz0 : sel == 1 ? bz1 : bz2;
    assign lvl_m  = sel == 0 ? lv0 : sel == 1 ? lv1 : lv2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: line level for every clock of one frame, appended to exp_q.
    function automatic void build(input logic [8:0] w, input int db, input int par, input int sb);
        int ones = 0;
        bit frame[$];
        frame.push_back(1'b0);
        for (int i = 0; i < db; i++) begin
            frame.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (par != 0) frame.push_back(bit'((ones % 2) ^ (par == 2 ? 1 : 0)));
        for (int i = 0; i < sb; i++) frame.push_back(1'b1);
        foreach (frame[i]) repeat (DIV) exp_q.push_back(frame[i]);
    endfunction

    task automatic send(input int s, input logic [8:0] w, input int db, input int par, input int sb, input string tag);
        sel = s;
        exp_q.delete();
        build(w, db, par, sb);
        vld = 1'b1;
        d = w;
        tick();
        vld = 1'b0;
        chk({tag, " level"}, 32'(lvl_m), 1);
        chk({tag, " busy"}, 32'(busy_m), 1);
        tick();
        for (int c = 0; c < exp_q.size(); c++) begin
            chk($sformatf("%s line c%0d", tag, c), 32'(line_m), 32'(exp_q[c]));
            tick();
        end
        chk({tag, " idle line"}, 32'(line_m), 1);
        chk({tag, " idle busy"}, 32'(busy_m), 0);
        chk({tag, " idle level"}, 32'(lvl_m), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, acc_at_drop, rise_e;
        bit seen_drop, hi;
        logic rpre;
        int words[6];
        #1 reset_n = 1'b0;
        #1;
        chk("reset line", 32'(tx0), 1);
        chk("reset busy", 32'(bz0), 0);
        chk("reset ready", 32'(rdy0), 1);
        chk("reset level", 32'(lv0), 0);
        chk("reset line u1", 32'(tx1), 1);
        #10 reset_n = 1'b1;
        tick();
        tick();

        send(0, 9'h055, 8, 0, 1, "8n1_55");
        repeat (3) send(0, 9'($urandom_range(0, 255)), 8, 0, 1, "8n1_rand");
        send(1, 9'h041, 7, 1, 2, "7e2_41");
        repeat (2) send(1, 9'($urandom_range(0, 127)), 7, 1, 2, "7e2_rand");
        send(2, 9'h000, 8, 2, 1, "8o1_00");
        send(2, 9'h0FF, 8, 2, 1, "8o1_ff");
        repeat (2) send(2, 9'($urandom_range(0, 255)), 8, 2, 1, "8o1_rand");

        sel = 0;
        exp_q.delete();
        words = '{1, 2, 3, 4, 5, 6};
        foreach (words[i]) build(9'(words[i]), 8, 0, 1);
        idx = 0;
        acc_at_drop = -1;
        rise_e = -1;
        seen_drop = 0;
        for (int e = 0; e < 260; e++) begin
            vld = idx < 6;
            d = (idx < 6) ? 9'(words[idx]) : 9'h0;
            rpre = rdy_m;
            tick();
            if (vld && rpre) idx++;
            chk($sformatf("burst line e%0d", e), 32'(line_m),
                (e >= 1 && e - 1 < exp_q.size()) ? 32'(exp_q[e-1]) : 32'd1);
            if (!rdy_m && !seen_drop) begin
                seen_drop = 1;
                acc_at_drop = idx;
            end
            if (rdy_m && seen_drop && rise_e < 0) rise_e = e;
        end
        vld = 1'b0;
        chk("burst accepted before full", acc_at_drop, 5);
        chk("burst ready rise edge", rise_e, 1 + 10 * DIV);
        chk("burst all accepted", idx, 6);
        chk("burst end busy", 32'(busy_m), 0);
        chk("burst end level", 32'(lvl_m), 0);

        sel = 0;
        vld = 1'b1;
        d = 9'h000;
        tick();
        d = 9'h0A5;
        tick();
        d = 9'h03C;
        tick();
        vld = 1'b0;
        repeat (15) tick();
        chk("abort pre level", 32'(lvl_m), 2);
        chk("abort pre line", 32'(line_m), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("abort line", 32'(line_m), 1);
        chk("abort level", 32'(lvl_m), 0);
        chk("abort busy", 32'(busy_m), 0);
        chk("abort ready", 32'(rdy_m), 1);
        vld = 1'b1;
        d = 9'h1FF;
        repeat (2) @(posedge clk);
        #2 vld = 1'b0;
        chk("in-reset level", 32'(lvl_m), 0);
        #2 reset_n = 1'b1;
        tick();
        chk("post-reset level", 32'(lvl_m), 0);
        chk("post-reset busy", 32'(busy_m), 0);
        chk("post-reset ready", 32'(rdy_m), 1);
        hi = 1;
        repeat (60) begin
            tick();
            if (line_m !== 1'b1) hi = 0;
        end
        chk("post-reset line stays high", 32'(hi), 1);
        chk("post-reset final busy", 32'(busy_m), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
